// File: rtl/imem_loader_pkg.sv
// Shared types and frame constants for the boot-time instruction memory loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        SYNC,
        LEN,
        DATA,
        CHK,
        DONE,
        ERROR
    } state_e;

    localparam logic [7:0] SYNC_BYTE  = 8'hA5;
    localparam int         LEN_BYTES  = 4;
    localparam int         WORD_BYTES = 4;
    localparam int         CHK_BYTES  = 1;

endpackage

// File: rtl/imem_word_packer.sv
// Little-endian byte-to-word assembler shared by the length and data fields.
// word_valid/word_data are presented in the same cycle as the final byte so the caller can register them.
module imem_word_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word_data
);

    logic [1:0]  idx_q, idx_d;
    logic [23:0] asm_q, asm_d;

    always_comb begin
        idx_d      = idx_q;
        asm_d      = asm_q;
        word_valid = byte_valid && (idx_q == 2'(WORD_BYTES - 1));
        word_data  = {byte_data, asm_q};
        if (clear) begin
            idx_d = '0;
            asm_d = '0;
        end else if (byte_valid) begin
            idx_d = idx_q + 2'd1;
            // Earlier bytes shift down so byte 0 ends up in bits [7:0].
            asm_d = {byte_data, asm_q[23:8]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q <= '0;
            asm_q <= '0;
        end else begin
            idx_q <= idx_d;
            asm_q <= asm_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Frame-parsing loader: writes a checksummed program image into instruction memory
// and holds the core in reset until a complete, valid image is stored.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int          ADDR_WIDTH = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  rx_ready,
    output logic                  imem_we,
    output logic [31:0]           imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  core_rst,
    output logic                  load_done,
    output logic                  load_err,
    output logic [ADDR_WIDTH:0]   word_count
);

    localparam int          CW        = ADDR_WIDTH + 1;
    localparam logic [31:0] MAX_WORDS = 32'(1) << ADDR_WIDTH;

    state_e          state_q, state_d;
    logic [7:0]      xor_q, xor_d;
    logic [CW-1:0]   len_q, len_d;
    logic [CW-1:0]   word_count_q, word_count_d;
    logic            rx_ready_q, rx_ready_d;
    logic            imem_we_q, imem_we_d;
    logic [31:0]     imem_addr_q, imem_addr_d;
    logic [31:0]     imem_wdata_q, imem_wdata_d;
    logic            core_rst_q, core_rst_d;
    logic            load_done_q, load_done_d;
    logic            load_err_q, load_err_d;

    logic            accept;
    logic            pk_byte_valid;
    logic            pk_clear;
    logic            pk_word_valid;
    logic [31:0]     pk_word;

    assign accept        = rx_valid && rx_ready_q;
    assign pk_byte_valid = accept && ((state_q == LEN) || (state_q == DATA));
    // Every state change restarts byte assembly, so a new field never inherits stale bytes.
    assign pk_clear      = (state_d != state_q);

    imem_word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (pk_clear),
        .byte_valid (pk_byte_valid),
        .byte_data  (rx_data),
        .word_valid (pk_word_valid),
        .word_data  (pk_word)
    );

    always_comb begin
        state_d      = state_q;
        xor_d        = xor_q;
        len_d        = len_q;
        word_count_d = word_count_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        load_done_d  = load_done_q;
        load_err_d   = load_err_q;

        case (state_q)
            SYNC: begin
                if (accept && (rx_data == SYNC_BYTE)) begin
                    state_d = LEN;
                end
            end
            LEN: begin
                if (pk_word_valid) begin
                    if (pk_word > MAX_WORDS) begin
                        state_d    = ERROR;
                        load_err_d = 1'b1;
                    end else if (pk_word == 32'd0) begin
                        state_d = CHK;
                    end else begin
                        state_d = DATA;
                        len_d   = pk_word[CW-1:0];
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    xor_d = xor_q ^ rx_data;
                end
                if (pk_word_valid) begin
                    imem_we_d    = 1'b1;
                    imem_addr_d  = BASE_ADDR + (32'(word_count_q) << 2);
                    imem_wdata_d = pk_word;
                    word_count_d = word_count_q + 1'b1;
                    if (word_count_d == len_q) begin
                        state_d = CHK;
                    end
                end
            end
            CHK: begin
                if (accept) begin
                    if (rx_data == xor_q) begin
                        state_d     = DONE;
                        load_done_d = 1'b1;
                    end else begin
                        state_d    = ERROR;
                        load_err_d = 1'b1;
                    end
                end
            end
            DONE, ERROR: begin
            end
            default: begin
                state_d = SYNC;
            end
        endcase

        // Registered from the next state so ready drops on the same edge that enters a terminal state.
        rx_ready_d = (state_d == SYNC) || (state_d == LEN) || (state_d == DATA) || (state_d == CHK);
        core_rst_d = (state_d != DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= SYNC;
            xor_q        <= '0;
            len_q        <= '0;
            word_count_q <= '0;
            rx_ready_q   <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= BASE_ADDR;
            imem_wdata_q <= '0;
            core_rst_q   <= 1'b1;
            load_done_q  <= 1'b0;
            load_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            xor_q        <= xor_d;
            len_q        <= len_d;
            word_count_q <= word_count_d;
            rx_ready_q   <= rx_ready_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            core_rst_q   <= core_rst_d;
            load_done_q  <= load_done_d;
            load_err_q   <= load_err_d;
        end
    end

    assign rx_ready   = rx_ready_q;
    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign core_rst   = core_rst_q;
    assign load_done  = load_done_q;
    assign load_err   = load_err_q;
    assign word_count = word_count_q;

endmodule
